// File: rtl/ccff_loader_pkg.sv
// Shared types and elaboration helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_SHIFT,
    ST_DONE
  } ccff_ld_state_e;

  // Bits of the final bitstream word that actually reach the chain.
  function automatic int unsigned last_word_bits(input int unsigned chain_len,
                                                 input int unsigned word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/ccff_readback_packer.sv
// Collects chain-tail bits MSB-first into left-aligned readback words;
// flush emits a partial word zero-padded at the bottom.
module ccff_readback_packer #(
  parameter int unsigned WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned CW = $clog2(WORD_W);
  localparam logic [CW-1:0] FULL_CNT = CW'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_next;
  logic [CW-1:0]     cnt_q;

  always_comb begin
    acc_next = acc_q;
    acc_next[FULL_CNT - cnt_q] = bit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (shift) begin
        if (flush || (cnt_q == FULL_CNT)) begin
          rb_data  <= acc_next;
          rb_valid <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first into a configuration FF chain,
// reads back the old contents and holds I/O isolation until fully loaded.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned WORD_W    = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TW        = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BW        = $clog2(WORD_W);
  localparam int unsigned LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
  localparam logic [TW-1:0] LAST_WORD_BASE = TW'(CHAIN_LEN - LAST_BITS);
  localparam logic [BW-1:0] LAST_STOP_IDX  = BW'(WORD_W - LAST_BITS);
  localparam logic [BW-1:0] TOP_IDX        = BW'(WORD_W - 1);

  ccff_ld_state_e    state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d, bit_idx_m1;
  logic [TW-1:0]     tot_cnt_q, tot_cnt_d;
  logic              last_word_q, last_word_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              ready_q, ready_d;
  logic              isol_n_q, isol_n_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              final_shift;
  logic              pk_clear, pk_shift, pk_flush;

  assign bit_idx_m1  = bit_idx_q - BW'(1);
  // Final bit is known from the word position alone; tot_cnt only marks which word is last.
  assign final_shift = last_word_q && (bit_idx_q == LAST_STOP_IDX);

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      bit_idx_q   <= '0;
      tot_cnt_q   <= '0;
      last_word_q <= 1'b0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      ready_q     <= 1'b0;
      isol_n_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_idx_q   <= bit_idx_d;
      tot_cnt_q   <= tot_cnt_d;
      last_word_q <= last_word_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      ready_q     <= ready_d;
      isol_n_q    <= isol_n_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_idx_d   = bit_idx_q;
    tot_cnt_d   = tot_cnt_q;
    last_word_d = last_word_q;
    head_d      = head_q;
    shift_en_d  = 1'b0;
    ready_d     = 1'b0;
    isol_n_d    = isol_n_q;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    pk_clear    = 1'b0;
    pk_shift    = 1'b0;
    pk_flush    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = (state_q == ST_DONE);
        if (start) begin
          state_d     = ST_LOAD_WAIT;
          tot_cnt_d   = '0;
          last_word_d = 1'b0;
          pk_clear    = 1'b1;
          isol_n_d    = 1'b0;
          done_d      = 1'b0;
          ready_d     = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ST_LOAD_WAIT: begin
        busy_d = 1'b1;
        if (cfg_valid) begin
          state_d     = ST_SHIFT;
          word_d      = cfg_data;
          bit_idx_d   = TOP_IDX;
          last_word_d = (tot_cnt_q == LAST_WORD_BASE);
          head_d      = cfg_data[WORD_W-1];
          shift_en_d  = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        pk_shift  = 1'b1;
        tot_cnt_d = tot_cnt_q + TW'(1);
        if (final_shift) begin
          pk_flush = 1'b1;
          state_d  = ST_DONE;
          done_d   = 1'b1;
          isol_n_d = 1'b1;
        end else if (bit_idx_q == '0) begin
          state_d = ST_LOAD_WAIT;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          bit_idx_d  = bit_idx_m1;
          head_d     = word_q[bit_idx_m1];
          shift_en_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      shift_en_d = 1'b0;
      ready_d    = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      isol_n_d   = isol_n_q;
      pk_clear   = 1'b1;
      pk_shift   = 1'b0;
      pk_flush   = 1'b0;
    end
  end

  ccff_readback_packer #(.WORD_W(WORD_W)) u_packer (
    .clk      (prog_clk),
    .rst      (prog_reset),
    .clear    (pk_clear),
    .shift    (pk_shift),
    .bit_in   (ccff_tail),
    .flush    (pk_flush),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

  assign cfg_ready     = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign isol_n        = isol_n_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
